// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between instruction fetch and load/store.
// Data wins conflicts unless fetch has waited MAX_WAIT cycles; read data returns one cycle after grant.
module ram_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              ram_write_enable,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_in,
   input  logic [DATA_W-1:0] ram_out
);
   typedef enum logic [1:0] {NONE, IF, D} tag_t;
   tag_t              tag, tag_nxt;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              d_align, d_ram, fetch_due;
   always_comb begin
      d_align          = d_req && d_addr[1:0] == 2'b00;
      fetch_due        = wait_cnt == 4'(MAX_WAIT);
      if_gnt           = !reset && if_req && (!d_align || fetch_due);
      d_gnt            = !reset && d_req && !(d_align && if_req && fetch_due);
      d_ram            = d_gnt && d_align;
      ram_write_enable = d_ram && d_we;
      ram_address      = if_gnt ? (if_addr & ~ADDR_W'(3)) : d_ram ? d_addr : addr_q;
      ram_in           = d_ram ? d_wdata : '0;
      tag_nxt          = if_gnt ? IF : (d_ram && !d_we) ? D : NONE;
   end
   // Misaligned data accesses never touch the RAM; they only produce an error pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag      <= NONE;
         wait_cnt <= '0;
         d_err    <= 1'b0;
         addr_q   <= '0;
      end else begin
         tag   <= tag_nxt;
         d_err <= d_gnt && !d_align;
         if (if_gnt) wait_cnt <= '0;
         else if (if_req && !fetch_due) wait_cnt <= wait_cnt + 4'd1;
         if (if_gnt || d_ram) addr_q <= ram_address;
      end
   end
   assign if_rvalid = tag == IF;
   assign d_rvalid  = tag == D;
   assign if_rdata  = ram_out;
   assign d_rdata   = ram_out;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed plan checks plus randomized traffic against a behavioural model.
module tb_ram_arbiter;
   localparam int AW = 32, DW = 32, MW = 3;
   logic          clock = 0, reset = 1;
   logic          if_req = 0, d_req = 0, d_we = 0;
   logic [AW-1:0] if_addr = 0, d_addr = 0;
   logic [DW-1:0] d_wdata = 0;
   logic          if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, ram_write_enable;
   logic [DW-1:0] if_rdata, d_rdata, ram_in, ram_out;
   logic [AW-1:0] ram_address;
   int            vectors = 0, miscompares = 0;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .ram_write_enable(ram_write_enable), .ram_address(ram_address), .ram_in(ram_in), .ram_out(ram_out)
   );

   always #5 clock = ~clock;

   // RAM with registered read port, 64 words
   logic [DW-1:0] mem [64] = '{default: '0};
   always @(posedge clock) begin
      if (ram_write_enable) mem[ram_address[7:2]] <= ram_in;
      ram_out <= mem[ram_address[7:2]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model
   logic [DW-1:0] ref_mem [64] = '{default: '0};
   int            m_wait = 0, p_tag = 0;
   logic [DW-1:0] p_data = 0;
   logic          p_err = 0, last_known = 0, aligned, fetch_wins, data_wins, uses_ram;
   logic [AW-1:0] last_addr = 0, exp_addr;
   logic          if_g_seen = 0, d_g_seen = 0;

   always @(negedge clock) begin
      if_g_seen = if_gnt;
      d_g_seen  = d_gnt;
      if (reset) begin
         check("rst_if_gnt", 32'(if_gnt), 0);
         check("rst_d_gnt", 32'(d_gnt), 0);
         check("rst_we", 32'(ram_write_enable), 0);
         check("rst_if_rvalid", 32'(if_rvalid), 0);
         check("rst_d_rvalid", 32'(d_rvalid), 0);
         check("rst_d_err", 32'(d_err), 0);
         m_wait = 0; p_tag = 0; p_err = 0; last_known = 0;
      end else begin
         check("if_rvalid", 32'(if_rvalid), 32'(p_tag == 1));
         check("d_rvalid", 32'(d_rvalid), 32'(p_tag == 2));
         if (p_tag == 1) check("if_rdata", if_rdata, p_data);
         if (p_tag == 2) check("d_rdata", d_rdata, p_data);
         check("d_err", 32'(d_err), 32'(p_err));
         aligned    = d_req && d_addr[1:0] == 2'b00;
         fetch_wins = if_req && (!aligned || m_wait >= MW);
         data_wins  = d_req && !(aligned && fetch_wins);
         uses_ram   = fetch_wins || (data_wins && aligned);
         check("if_gnt", 32'(if_gnt), 32'(fetch_wins));
         check("d_gnt", 32'(d_gnt), 32'(data_wins));
         check("ram_we", 32'(ram_write_enable), 32'(data_wins && aligned && d_we));
         exp_addr = fetch_wins ? {if_addr[AW-1:2], 2'b00} : uses_ram ? d_addr : last_addr;
         if (uses_ram || last_known) check("ram_address", ram_address, exp_addr);
         if (data_wins && aligned) check("ram_in", ram_in, d_wdata);
         else if (!fetch_wins) check("ram_in_idle", ram_in, 0);
         p_tag  = fetch_wins ? 1 : (data_wins && aligned && !d_we) ? 2 : 0;
         p_data = ref_mem[exp_addr[7:2]];
         p_err  = data_wins && !aligned;
         if (data_wins && aligned && d_we) ref_mem[d_addr[7:2]] = d_wdata;
         m_wait = fetch_wins ? 0 : if_req ? (m_wait < MW ? m_wait + 1 : MW) : m_wait;
         if (uses_ram) begin last_addr = exp_addr; last_known = 1; end
      end
   end

   task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                       input logic [31:0] da, input logic [31:0] dwd);
      @(posedge clock); #1;
      if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
      @(negedge clock); #1;
   endtask

   logic [7:0] pat = 8'b1000_1000;

   initial begin
      repeat (2) @(negedge clock);
      #1;
      check("t0_rst_rvalid", 32'(d_rvalid | if_rvalid), 0);
      reset = 0;
      // store 10 @4, load it back
      step(0, 0, 1, 1, 4, 10);
      check("t1_st_gnt", 32'(d_gnt), 1);
      check("t1_st_we", 32'(ram_write_enable), 1);
      check("t1_st_addr", ram_address, 4);
      step(0, 0, 1, 0, 4, 0);
      check("t1_ld_gnt", 32'(d_gnt), 1);
      step(0, 0, 0, 0, 0, 0);
      check("t1_ld_rvalid", 32'(d_rvalid), 1);
      check("t1_ld_rdata", d_rdata, 10);
      check("t1_if_rvalid", 32'(if_rvalid), 0);
      // store 20 @4, fetch at 6
      step(0, 0, 1, 1, 4, 20);
      step(1, 6, 0, 0, 0, 0);
      check("t2_if_gnt", 32'(if_gnt), 1);
      check("t2_addr", ram_address, 4);
      step(0, 0, 0, 0, 0, 0);
      check("t2_if_rvalid", 32'(if_rvalid), 1);
      check("t2_if_rdata", if_rdata, 20);
      // continuous conflict: D,D,D,IF,D,D,D,IF
      for (int k = 0; k < 8; k++) begin
         step(1, 'h10, 1, 0, 'h20, 0);
         check("t3_if_gnt", 32'(if_gnt), 32'(pat[k]));
         check("t3_d_gnt", 32'(d_gnt), 32'(!pat[k]));
      end
      // misaligned store with fetch in the same cycle
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 1, 5, 'hdead);
      check("t4_if_gnt", 32'(if_gnt), 1);
      check("t4_d_gnt", 32'(d_gnt), 1);
      check("t4_we", 32'(ram_write_enable), 0);
      step(0, 0, 0, 0, 0, 0);
      check("t4_err", 32'(d_err), 1);
      check("t4_if_rvalid", 32'(if_rvalid), 1);
      check("t4_d_rvalid", 32'(d_rvalid), 0);
      step(0, 0, 0, 0, 0, 0);
      check("t4_err_once", 32'(d_err), 0);
      step(0, 0, 1, 0, 4, 0);
      step(0, 0, 0, 0, 0, 0);
      check("t4_mem4", d_rdata, 20);
      // store then immediate load
      step(0, 0, 1, 1, 8, 'h55);
      step(0, 0, 1, 0, 8, 0);
      step(0, 0, 0, 0, 0, 0);
      check("t5_rvalid", 32'(d_rvalid), 1);
      check("t5_rdata", d_rdata, 'h55);
      // reset before a load response
      step(0, 0, 1, 0, 8, 0);
      check("t6_gnt", 32'(d_gnt), 1);
      reset = 1; d_req = 0;
      @(negedge clock); #1;
      check("t6_rst_d_rvalid", 32'(d_rvalid), 0);
      check("t6_rst_gnt", 32'(d_gnt | if_gnt), 0);
      reset = 0;
      step(0, 0, 0, 0, 0, 0);
      check("t6_no_rvalid", 32'(d_rvalid), 0);
      // randomized traffic, requests held until granted
      repeat (3000) begin
         @(posedge clock); #1;
         if (!if_req || if_g_seen) begin
            if_req  = $urandom_range(0, 3) != 0;
            if_addr = $urandom_range(0, 255);
         end
         if (!d_req || d_g_seen) begin
            d_req   = $urandom_range(0, 3) != 0;
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = {$urandom_range(0, 63), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            d_wdata = $urandom;
         end
         if ($urandom_range(0, 299) == 0) begin
            reset = 1; if_req = 0; d_req = 0;
            @(negedge clock); #1;
            reset = 0;
         end
      end
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between the instruction-fetch requester (read-only) and the load/store requester (read/write).
- Selects one request per cycle and drives the RAM address, write-data and write-enable inputs.
- Returns read data to the owning requester one cycle after grant.
- Default priority goes to data accesses; a wait counter bounds how long fetch can be starved.

Parameters:
- ADDR_W, 32, byte-address width of both requesters and the RAM.
- DATA_W, 32, word width.
- MAX_WAIT, 3, number of consecutive denied fetch cycles after which fetch wins the next conflict (1..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid (registered).
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  load data valid (registered).
- d_rdata  out  DATA_W  load data.
- d_err  out  1  one-cycle pulse: misaligned data access rejected.
- ram_write_enable  out  1  to RAM write_enable.
- ram_address  out  ADDR_W  to RAM address, always word aligned.
- ram_in  out  DATA_W  to RAM in.
- ram_out  in  DATA_W  from RAM out; registered, valid the cycle after the address is presented.

Behaviour:
- Reset values (asynchronous): if_rvalid = d_rvalid = d_err = 0; wait counter = 0; response tag = NONE.
- While reset is high: if_gnt = d_gnt = ram_write_enable = 0.
- Arbitration per cycle, combinational. Aligned data means d_req=1 and d_addr[1:0]=00.
  - Only one requester active: it is granted.
  - Both active: data is granted, unless wait counter == MAX_WAIT, in which case fetch is granted.
  - A misaligned data request (d_req=1, d_addr[1:0]!=00) is granted immediately without a RAM access. Fetch may use the RAM in the same cycle; no conflict arises.
- RAM drive:
  - Fetch granted: ram_address = {if_addr[ADDR_W-1:2],00}, ram_write_enable = 0.
  - Aligned data granted: ram_address = d_addr, ram_in = d_wdata, ram_write_enable = d_we.
  - Idle: ram_write_enable = 0, ram_address holds its previous value (registered mux select), ram_in = 0.
- Response tag register (states NONE / IF / D), set at the edge after a read grant:
  - Fetch grant -> IF.
  - Aligned load grant -> D.
  - Store, misaligned access or idle -> NONE.
- Response outputs:
  - Tag IF: if_rvalid = 1 and if_rdata = ram_out.
  - Tag D: d_rvalid = 1 and d_rdata = ram_out.
  - rdata outputs are don't-care when their rvalid = 0.
- Throughput and latency:
  - Back-to-back grants every cycle are permitted; read latency is exactly 1 cycle after grant.
  - A store is complete at the edge ending its grant cycle, so a load to the same address granted in the next cycle returns the new data.
- d_err: registered pulse, high exactly one cycle after the misaligned grant; no d_rvalid is produced for that access.
- Wait counter:
  - +1 (saturating at MAX_WAIT) on each cycle with if_req=1 and if_gnt=0.
  - Cleared on if_gnt.
  - Held when if_req=0.
- Reset asserted mid-transaction: the pending response is dropped (no rvalid after release) and the counter is cleared. Requesters re-issue after reset.

Test Plan:
- Reset then release; write via data port (addr 4, wdata 10, we=1), then load addr 4 -> d_gnt in the request cycle, d_rvalid=1 with d_rdata=10 exactly one cycle later; if_rvalid stays 0.
- Fetch alone at if_addr=0x6 after a store of 20 to addr 4 -> ram_address=0x4, if_rvalid next cycle with if_rdata=20.
- Both requesters held high continuously, MAX_WAIT=3 -> grant pattern D,D,D,IF,D,D,D,IF; counter returns to 0 after each IF grant.
- Misaligned store d_addr=0x5, we=1, with fetch pending in the same cycle -> both granted, ram_write_enable=0, d_err pulses once next cycle, if_rvalid next cycle, memory at 0x4 unchanged.
- Store 0x55 to addr 8 in cycle N, load addr 8 in cycle N+1 -> d_rdata=0x55 in cycle N+2.
- Load granted, reset pulsed before the response edge -> no d_rvalid after reset release; all outputs 0 during reset.
